// File: rtl/xsz_pkg.sv
// Shared definitions for the wide-to-narrow write sequencer.
// Contents: sequencer state encoding, width helper functions and a
// request record sized for the default 19-bit address / 64-bit data path.
package xsz_pkg;

    typedef enum logic {
        XS_IDLE = 1'b0,
        XS_SEND = 1'b1
    } xsz_seq_st_e;

    localparam int XS_AW  = 19;
    localparam int XS_DWI = 64;

    // Number of narrow beats that make up one wide word.
    function automatic int nb_f(input int dwi, input int dwo);
        return dwi / dwo;
    endfunction

    // Address bit where the beat index starts (log2 of narrow bytes).
    function automatic int lo_f(input int dwo);
        return $clog2(dwo / 8);
    endfunction

    typedef struct packed {
        logic [XS_AW-1:0]    adr;
        logic [XS_DWI-1:0]   dat;
        logic [XS_DWI/8-1:0] strb;
    } req_t;

endpackage

// File: rtl/xsz_beat_seq_if.sv
// Bundle of the wide request port and the narrow beat port of the sequencer.
// Signal suffixes are written from the sequencer's point of view.
//   req_*  : wide request (vld/rdy, byte address, data, byte strobes)
//   beat_* : narrow beat (vld/rdy, byte address, data, strobes, last)
//   busy_o : a request is currently held
// Modports: slave = the sequencer, master = whoever drives requests and
// accepts beats.
interface xsz_beat_seq_if #(
    parameter int AW  = 19,
    parameter int DWI = 64,
    parameter int DWO = 32
);
    logic               req_vld_i;
    logic               req_rdy_o;
    logic [AW-1:0]      req_adr_i;
    logic [DWI-1:0]     req_dat_i;
    logic [DWI/8-1:0]   req_strb_i;
    logic               beat_vld_o;
    logic               beat_rdy_i;
    logic [AW-1:0]      beat_adr_o;
    logic [DWO-1:0]     beat_dat_o;
    logic [DWO/8-1:0]   beat_strb_o;
    logic               beat_last_o;
    logic               busy_o;

    modport slave (
        input  req_vld_i, req_adr_i, req_dat_i, req_strb_i, beat_rdy_i,
        output req_rdy_o, beat_vld_o, beat_adr_o, beat_dat_o, beat_strb_o,
               beat_last_o, busy_o
    );

    modport master (
        output req_vld_i, req_adr_i, req_dat_i, req_strb_i, beat_rdy_i,
        input  req_rdy_o, beat_vld_o, beat_adr_o, beat_dat_o, beat_strb_o,
               beat_last_o, busy_o
    );
endinterface

// File: rtl/xsz_next_beat.sv
// Masked priority finder over per-beat "issuable" flags.
// Ports:
//   flag_i    : one bit per beat index, 1 = beat may be issued
//   k_i       : reference index
//   next_k_o  : lowest flagged index above k_i (or >= k_i when INCL=1)
//   found_o   : such an index exists
//   is_last_o : found, and no further flagged index lies beyond next_k_o
// Purely combinational.
module xsz_next_beat #(
    parameter int NB   = 2,
    parameter int KW   = 1,
    parameter bit INCL = 1'b0
) (
    input  logic [NB-1:0] flag_i,
    input  logic [KW-1:0] k_i,
    output logic [KW-1:0] next_k_o,
    output logic          found_o,
    output logic          is_last_o
);
    logic [NB-1:0] mask;
    logic          hit;
    logic          later;

    // Only indices past the reference (or at it, for the start search)
    // are candidates.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_mask
            assign mask[gi] = flag_i[gi] &&
                              ((gi > int'(k_i)) || (INCL && (gi == int'(k_i))));
        end
    endgenerate

    always_comb begin
        hit      = 1'b0;
        later    = 1'b0;
        next_k_o = '0;
        for (int i = 0; i < NB; i++) begin
            if (mask[i]) begin
                if (hit) begin
                    later = 1'b1;
                end else begin
                    hit      = 1'b1;
                    next_k_o = KW'(i);
                end
            end
        end
    end

    assign found_o   = hit;
    assign is_last_o = hit & ~later;
endmodule

// File: rtl/xsz_beat_seq.sv
// Wide-to-narrow write sequencer. Captures one wide request and replays it
// as consecutive narrow beats, each with its own address, data slice,
// strobe slice and last flag. With SKIP_EMPTY=1 beats whose strobe slice is
// all zero are never issued; an all-empty request is consumed silently.
// Ports:
//   clk_i  : clock, rising edge
//   rstn_i : asynchronous active-low reset
//   bus    : request + beat handshake bundle (slave side)
module xsz_beat_seq
    import xsz_pkg::*;
#(
    parameter int AW         = 19,
    parameter int DWI        = 64,
    parameter int DWO        = 32,
    parameter bit SKIP_EMPTY = 1'b1
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    xsz_beat_seq_if.slave  bus
);
    localparam int NB = nb_f(DWI, DWO);
    localparam int LO = lo_f(DWO);
    localparam int HI = $clog2(DWI / 8) - 1;
    localparam int KW = $clog2(NB);
    localparam int SB = DWO / 8;

    localparam logic [0:0] ST_IDLE = XS_IDLE;
    localparam logic [0:0] ST_SEND = XS_SEND;

    logic [0:0]        state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic              last_q, last_d;
    logic [AW-HI-2:0]  adr_q, adr_d;     // only the wide-word address is kept
    logic [DWI-1:0]    dat_q, dat_d;
    logic [DWI/8-1:0]  strb_q, strb_d;

    logic [NB-1:0]     req_ne;
    logic [NB-1:0]     cap_ne;
    logic [KW-1:0]     st_k, nx_k;
    logic              st_found, st_last;
    logic              nx_found, nx_last;
    logic              send, beat_hs, req_rdy, accept;
    logic              unused_adr_lo;

    // Issuable-beat flags, from the incoming request (start search) and
    // from the captured request (advance search).
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_flags
            assign req_ne[gi] = SKIP_EMPTY ? (|bus.req_strb_i[gi*SB +: SB]) : 1'b1;
            assign cap_ne[gi] = SKIP_EMPTY ? (|strb_q[gi*SB +: SB]) : 1'b1;
        end
    endgenerate

    xsz_next_beat #(.NB(NB), .KW(KW), .INCL(1'b1)) u_start (
        .flag_i    (req_ne),
        .k_i       (bus.req_adr_i[HI:LO]),
        .next_k_o  (st_k),
        .found_o   (st_found),
        .is_last_o (st_last)
    );

    xsz_next_beat #(.NB(NB), .KW(KW), .INCL(1'b0)) u_next (
        .flag_i    (cap_ne),
        .k_i       (k_q),
        .next_k_o  (nx_k),
        .found_o   (nx_found),
        .is_last_o (nx_last)
    );

    assign send    = (state_q == ST_SEND);
    assign beat_hs = send & bus.beat_rdy_i;
    // Ready while idle, or when the final beat leaves this cycle so the
    // next request follows without a bubble (combinational from beat_rdy_i).
    assign req_rdy = rstn_i & (~send | (last_q & bus.beat_rdy_i));
    assign accept  = bus.req_vld_i & req_rdy;

    // Sub-beat address bits are deliberately dropped.
    assign unused_adr_lo = ^bus.req_adr_i[LO-1:0];

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        last_d  = last_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        strb_d  = strb_q;
        if (accept) begin
            adr_d  = bus.req_adr_i[AW-1:HI+1];
            dat_d  = bus.req_dat_i;
            strb_d = bus.req_strb_i;
            if (st_found) begin
                state_d = ST_SEND;
                k_d     = st_k;
                last_d  = st_last;
            end else begin
                state_d = ST_IDLE;
                last_d  = 1'b0;
            end
        end else if (beat_hs) begin
            if (last_q) begin
                state_d = ST_IDLE;
                last_d  = 1'b0;
            end else if (nx_found) begin
                k_d    = nx_k;
                last_d = nx_last;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            last_q  <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            last_q  <= last_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            strb_q  <= strb_d;
        end
    end

    assign bus.req_rdy_o   = req_rdy;
    assign bus.beat_vld_o  = send;
    assign bus.busy_o      = send;
    assign bus.beat_last_o = send & last_q;
    assign bus.beat_adr_o  = {adr_q, k_q, {LO{1'b0}}};
    assign bus.beat_dat_o  = dat_q[k_q*DWO +: DWO];
    assign bus.beat_strb_o = strb_q[k_q*SB +: SB];
endmodule
